// File: rtl/bus_pkg.sv
// Shared serial-bus types and default widths for the arbiter and its slave ports.
package bus_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
    WR,
    RD_REQ,
    RD_WAIT,
    TX
  } slave_state_t;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_bram.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module slave_bram
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = 4096,
  localparam int IDX_W     = width_for(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/slave_port.sv
// Serial-bus responder: deserialises address/write data, accesses local RAM, serialises read data.
// Optional SLAVE_PORT_RANGE_CHK_EN: out-of-range writes dropped, out-of-range reads return all ones.
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic clk,
  input  logic rstn,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid
);

  localparam int IDX_W = width_for(MEM_DEPTH);
  localparam int CNT_W = width_for(max_int(ADDR_WIDTH, DATA_WIDTH));
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  slave_state_t          r_state;
  mode_t                 r_mode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_slave_ready;
  logic                  r_slave_valid;

  logic                  w_rx_beat;
  logic                  w_tx_beat;
  logic                  w_we;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_rx_beat = master_valid && r_slave_ready;
  assign w_tx_beat = r_slave_valid && master_ready;
  assign w_idx     = r_addr[IDX_W-1:0];

`ifdef SLAVE_PORT_RANGE_CHK_EN
  logic w_in_range;
  // Zero-extend so the compare is exact even when MEM_DEPTH == 2**ADDR_WIDTH.
  assign w_in_range = ({1'b0, r_addr} < (ADDR_WIDTH + 1)'(MEM_DEPTH));
  assign w_we       = (r_state == WR) && w_in_range;
  assign w_load     = w_in_range ? w_rdata : '1;
`else
  assign w_we       = (r_state == WR);
  assign w_load     = w_rdata;
`endif

  slave_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_bram (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_idx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_mode        <= READ;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_slave_ready <= 1'b1;
      r_slave_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rx_beat) begin
            r_mode <= mode_t'(mode);
            r_addr <= (r_addr << 1) | ADDR_WIDTH'(wr_bus);
            if (ADDR_WIDTH == 1) begin
              r_cnt <= '0;
              if (mode_t'(mode) == WRITE) begin
                r_state <= RX_DATA;
              end else begin
                r_state       <= RD_REQ;
                r_slave_ready <= 1'b0;
              end
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= RX_ADDR;
            end
          end
        end
        RX_ADDR: begin
          if (w_rx_beat) begin
            r_addr <= (r_addr << 1) | ADDR_WIDTH'(wr_bus);
            if (r_cnt == ADDR_LAST) begin
              r_cnt <= '0;
              if (r_mode == WRITE) begin
                r_state <= RX_DATA;
              end else begin
                r_state       <= RD_REQ;
                r_slave_ready <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_beat) begin
            r_wdata <= (r_wdata << 1) | DATA_WIDTH'(wr_bus);
            if (r_cnt == DATA_LAST) begin
              r_cnt         <= '0;
              r_state       <= WR;
              r_slave_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        WR: begin
          r_state       <= IDLE;
          r_slave_ready <= 1'b1;
        end
        RD_REQ: begin
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          r_shift       <= w_load;
          r_slave_valid <= 1'b1;
          r_state       <= TX;
        end
        TX: begin
          if (w_tx_beat) begin
            r_shift <= r_shift << 1;
            if (r_cnt == DATA_LAST) begin
              r_cnt         <= '0;
              r_slave_valid <= 1'b0;
              r_slave_ready <= 1'b1;
              r_state       <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_slave_ready <= 1'b1;
          r_slave_valid <= 1'b0;
        end
      endcase
    end
  end

  // Shift register drains to zero, so rd_bus idles low after a transfer and after reset.
  assign rd_bus      = r_shift[DATA_WIDTH-1];
  assign slave_ready = r_slave_ready;
  assign slave_valid = r_slave_valid;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: two instances (4096-word and 16-word memory) driven in lockstep and
// checked every cycle against a frame-level timing model and a plain array memory model.
module tb_slave_port;

`ifdef SLAVE_PORT_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic mode, wr_bus, master_valid, master_ready;
  logic rd_a, sr_a, sv_a;
  logic rd_b, sr_b, sv_b;

  always #5 clk = ~clk;

  slave_port dut_a (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid),
    .master_ready(master_ready), .rd_bus(rd_a), .slave_ready(sr_a), .slave_valid(sv_a)
  );

  slave_port #(.MEM_DEPTH(16)) dut_b (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid),
    .master_ready(master_ready), .rd_bus(rd_b), .slave_ready(sr_b), .slave_valid(sv_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle, set by the driver just after each posedge.
  logic chk_en = 1'b0;
  logic exp_ready, exp_valid, exp_rd_a, exp_rd_b;

  logic [7:0] mem_a [4096];
  logic [7:0] mem_b [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_wr(input int a, input logic [7:0] d);
    mem_a[a % 4096] = d;
    if (!RANGE_CHK) mem_b[a % 16] = d;
    else if (a < 16) mem_b[a] = d;
  endfunction

  function automatic logic [7:0] model_rd_a(input int a);
    return mem_a[a % 4096];
  endfunction

  function automatic logic [7:0] model_rd_b(input int a);
    if (RANGE_CHK && a >= 16) return 8'hFF;
    return mem_b[a % 16];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_a", sr_a, exp_ready);
      chk("valid_a", sv_a, exp_valid);
      chk("ready_b", sr_b, exp_ready);
      chk("valid_b", sv_b, exp_valid);
      if (exp_valid) begin
        chk("rd_a", rd_a, exp_rd_a);
        chk("rd_b", rd_b, exp_rd_b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    master_valid = 1'b0;
    master_ready = 1'b0;
    exp_ready    = 1'b1;
    exp_valid    = 1'b0;
  endtask

  // One RX beat preceded by `gap` cycles of master_valid low carrying junk on wr_bus/mode.
  task automatic send_bit(input logic b, input logic m, input int gap);
    for (int g = 0; g < gap; g++) begin
      master_valid = 1'b0; wr_bus = ~b; mode = ~m;
      exp_ready = 1'b1; exp_valid = 1'b0;
      step();
    end
    master_valid = 1'b1; wr_bus = b; mode = m;
    exp_ready = 1'b1; exp_valid = 1'b0;
    step();
    master_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic m, input logic [11:0] addr, input int gap);
    for (int i = 11; i >= 0; i--) send_bit(addr[i], (i == 11) ? m : ~m, gap);
  endtask

  task automatic write_frame(input logic [11:0] addr, input logic [7:0] data, input int gap);
    send_hdr(1'b1, addr, gap);
    for (int i = 7; i >= 0; i--) send_bit(data[i], 1'b0, gap);
    exp_ready = 1'b0; exp_valid = 1'b0;
    step();
    model_wr(int'(addr), data);
    set_idle();
    $display("write addr=%03h data=%02h gap=%0d", addr, data, gap);
  endtask

  // mr_pat supplies master_ready cyclically (bit 0 first); abort_at >= 0 stops after that many beats.
  task automatic read_frame(input logic [11:0] addr, input int gap, input logic [3:0] mr_pat,
                            input int abort_at, output logic [7:0] got_a, output logic [7:0] got_b);
    logic [7:0] ea, eb;
    int k, c;
    got_a = 'x; got_b = 'x;
    send_hdr(1'b0, addr, gap);
    exp_ready = 1'b0; exp_valid = 1'b0;
    step();
    step();
    ea = model_rd_a(int'(addr));
    eb = model_rd_b(int'(addr));
    k = 0; c = 0;
    while (k < 8 && c < 64) begin
      if (abort_at == k) return;
      master_ready = mr_pat[c % 4];
      c++;
      exp_ready = 1'b0; exp_valid = 1'b1;
      exp_rd_a = ea[7-k]; exp_rd_b = eb[7-k];
      if (master_ready) begin
        got_a[7-k] = rd_a;
        got_b[7-k] = rd_b;
        k++;
      end
      step();
    end
    chk("tx_beats", k, 8);
    set_idle();
    $display("read  addr=%03h got_a=%02h got_b=%02h exp_a=%02h exp_b=%02h", addr, got_a, got_b, ea, eb);
  endtask

  logic [7:0] ga, gb;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_rd_a = 1'b0; exp_rd_b = 1'b0;
    repeat (2) step();
    chk("rst_ready", sr_a, 1'b1);
    chk("rst_valid", sv_a, 1'b0);
    chk("rst_rd", rd_a, 1'b0);
    rstn = 1'b1;
    set_idle();
    chk_en = 1'b1;
    step();

    // Write then read back 0x005 = 0xA5 (bit order 1,0,1,0,0,1,0,1).
    write_frame(12'h005, 8'hA5, 0);
    read_frame(12'h005, 0, 4'b1111, -1, ga, gb);
    chk("lit_a5_a", ga, 8'hA5);
    chk("lit_a5_b", gb, 8'hA5);

    // Reset in the middle of TX: outputs must return to reset values immediately.
    read_frame(12'h005, 0, 4'b1111, 3, ga, gb);
    chk_en = 1'b0;
    master_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid_a", sv_a, 1'b0);
    chk("midrst_ready_a", sr_a, 1'b1);
    chk("midrst_rd_a", rd_a, 1'b0);
    chk("midrst_valid_b", sv_b, 1'b0);
    chk("midrst_ready_b", sr_b, 1'b1);
    chk("midrst_rd_b", rd_b, 1'b0);
    $display("reset asserted mid-TX");
    step();
    rstn = 1'b1;
    set_idle();
    chk_en = 1'b1;
    step();
    read_frame(12'h005, 0, 4'b1111, -1, ga, gb);
    chk("post_rst_a", ga, 8'hA5);

    // master_ready stalls 1,0,0,1,...
    read_frame(12'h005, 0, 4'b1001, -1, ga, gb);
    chk("stall_a", ga, 8'hA5);

    // Three idle cycles between every bit.
    write_frame(12'h123, 8'h3C, 3);
    read_frame(12'h123, 3, 4'b1111, -1, ga, gb);
    chk("gap_a", ga, 8'h3C);

    // Back-to-back writes at both ends of the address space, then reads.
    write_frame(12'h000, 8'h11, 0);
    write_frame(12'hFFF, 8'h22, 0);
    read_frame(12'h000, 0, 4'b1111, -1, ga, gb);
    chk("lit_000_a", ga, 8'h11);
    chk("lit_000_b", gb, 8'h11);
    read_frame(12'hFFF, 0, 4'b0110, -1, ga, gb);
    chk("lit_fff_a", ga, 8'h22);
    chk("lit_fff_b", gb, RANGE_CHK ? 8'hFF : 8'h22);

    // Address 0x010 is out of range for the 16-word instance.
    write_frame(12'h010, 8'h77, 0);
    read_frame(12'h010, 0, 4'b1111, -1, ga, gb);
    chk("lit_010_a", ga, 8'h77);
    chk("lit_010_b", gb, RANGE_CHK ? 8'hFF : 8'h77);
    read_frame(12'h000, 0, 4'b1111, -1, ga, gb);
    chk("lit_alias_a", ga, 8'h11);
    chk("lit_alias_b", gb, RANGE_CHK ? 8'h11 : 8'h77);

    repeat (3) step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
